// File: rtl/counter_checker.sv
// ---------------------------------------------------------------------------
// counter_checker
//   Passive monitor for the output bus of an up/down counter. Every clock it
//   samples the counter value together with the counter's enable, predicts the
//   value the next sample must hold, and compares. It reports mismatches,
//   counts them in a saturating counter, and pulses once on each correctly
//   observed wrap through the terminal count.
//
//   Two states: SYNC (first sample after reset or loss of lock, no compare)
//   and TRACK (compare every sample). LOSS_TH consecutive mismatches in TRACK
//   drop the checker back to SYNC.
//
// Optional feature (macro CNT_CHK_DIR_EN):
//   When defined, an extra input 'dir' selects the counting direction per
//   sample (1 = decrement, 0 = increment) and DOWN is ignored. When undefined
//   the direction is fixed by DOWN.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset, overrides every other input
//   en         in   enable of the checked counter
//   cnt_in     in   [N]     checked counter output
//   clr        in   synchronous clear of err_cnt / err_sticky / run length
//   dir        in   (CNT_CHK_DIR_EN only) 1 = down, 0 = up
//   sync_ok    out  checker is locked (TRACK)
//   exp_out    out  [N]     predicted value of the next sample
//   err_pulse  out  one-cycle pulse per mismatch
//   err_sticky out  set by any mismatch, cleared by clr or rst
//   err_cnt    out  [ERR_W] saturating mismatch count
//   wrap_pulse out  one-cycle pulse per correctly predicted terminal wrap
// ---------------------------------------------------------------------------
module counter_checker #(
  parameter int N       = 4,
  parameter int DOWN    = 1,
  parameter int ERR_W   = 8,
  parameter int LOSS_TH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     cnt_in,
  input  logic             clr,
`ifdef CNT_CHK_DIR_EN
  input  logic             dir,
`endif
  output logic             sync_ok,
  output logic [N-1:0]     exp_out,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap_pulse
);

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_e;

  localparam logic [N-1:0]     CNT_ONE  = N'(1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] LOSS_CNT = ERR_W'(LOSS_TH);

  state_e           state_q,      state_d;
  logic             sync_ok_q,    sync_ok_d;
  logic [N-1:0]     exp_q,        exp_d;
  logic             err_pulse_q,  err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0] err_cnt_q,    err_cnt_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [ERR_W-1:0] run_q,        run_d;     // consecutive mismatches
  logic             armed_q,      armed_d;   // last sample sat on terminal count with en

  logic         down_sel;
  logic [N-1:0] next_val;
  logic [N-1:0] term_val;
  logic         match;

`ifdef CNT_CHK_DIR_EN
  assign down_sel = dir;
`else
  assign down_sel = (DOWN != 0);
`endif

  assign next_val = en ? (down_sel ? cnt_in - CNT_ONE : cnt_in + CNT_ONE) : cnt_in;
  assign term_val = down_sel ? '0 : '1;
  assign match    = (cnt_in == exp_q);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    state_d      = state_q;
    sync_ok_d    = sync_ok_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    run_d        = run_q;

    // The prediction always re-aligns to what was observed, so a single
    // corrupted sample shows up as two mismatches.
    exp_d   = next_val;
    // A wrap is only credited if the next sample then matches the prediction,
    // which for an armed sample is exactly the wrapped value.
    armed_d = en && (cnt_in == term_val);

    unique case (state_q)
      SYNC: begin
        state_d   = TRACK;
        sync_ok_d = 1'b1;
      end
      TRACK: begin
        err_pulse_d  = !match;
        wrap_pulse_d = match && armed_q;
        if (!match) begin
          err_sticky_d = 1'b1;
          if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_ONE;
          if (run_q == LOSS_CNT - ERR_ONE) begin
            state_d   = SYNC;
            sync_ok_d = 1'b0;
            run_d     = '0;
          end else begin
            run_d = run_q + ERR_ONE;
          end
        end else begin
          run_d = '0;
        end
      end
      default: begin
        state_d   = SYNC;
        sync_ok_d = 1'b0;
      end
    endcase

    // clr wins over a same-edge mismatch for the statistics only; the state
    // transition and err_pulse still follow the compare.
    if (clr) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
      run_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    if (rst) begin
      state_q      <= SYNC;
      sync_ok_q    <= 1'b0;
      exp_q        <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      wrap_pulse_q <= 1'b0;
      run_q        <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_ok_q    <= sync_ok_d;
      exp_q        <= exp_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      wrap_pulse_q <= wrap_pulse_d;
      run_q        <= run_d;
      armed_q      <= armed_d;
    end
  end

  assign sync_ok    = sync_ok_q;
  assign exp_out    = exp_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_counter_checker.sv
// ---------------------------------------------------------------------------
// tb_counter_checker
//   Drives directed counter sequences into two checker instances that share
//   all inputs: one with ERR_W=8 and one with ERR_W=2 (to reach saturation).
//   A sample-history model predicts every output and is compared each cycle;
//   hand-computed literal expectations pin key points of the sequence.
// ---------------------------------------------------------------------------
module tb_counter_checker;

  localparam int N       = 4;
  localparam int DOWN    = 1;
  localparam int ERR_W   = 8;
  localparam int SAT_W   = 2;
  localparam int LOSS_TH = 3;
  localparam int MODN    = 1 << N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] cnt_in = '0;
`ifdef CNT_CHK_DIR_EN
  logic         dir = 1'b1;
`endif

  logic             a_sync_ok, a_err_pulse, a_err_sticky, a_wrap_pulse;
  logic [N-1:0]     a_exp_out;
  logic [ERR_W-1:0] a_err_cnt;
  logic             b_sync_ok, b_err_pulse, b_err_sticky, b_wrap_pulse;
  logic [N-1:0]     b_exp_out;
  logic [SAT_W-1:0] b_err_cnt;

  always #5 clk = ~clk;

  counter_checker #(.N(N), .DOWN(DOWN), .ERR_W(ERR_W), .LOSS_TH(LOSS_TH)) dut (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .clr(clr),
`ifdef CNT_CHK_DIR_EN
    .dir(dir),
`endif
    .sync_ok(a_sync_ok), .exp_out(a_exp_out), .err_pulse(a_err_pulse),
    .err_sticky(a_err_sticky), .err_cnt(a_err_cnt), .wrap_pulse(a_wrap_pulse)
  );

  counter_checker #(.N(N), .DOWN(DOWN), .ERR_W(SAT_W), .LOSS_TH(LOSS_TH)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .clr(clr),
`ifdef CNT_CHK_DIR_EN
    .dir(dir),
`endif
    .sync_ok(b_sync_ok), .exp_out(b_exp_out), .err_pulse(b_err_pulse),
    .err_sticky(b_err_sticky), .err_cnt(b_err_cnt), .wrap_pulse(b_wrap_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keeps the previous sample itself and evaluates the rules on it directly.
  function automatic int predict(input int v, input bit e, input bit d);
    if (!e) return v;
    return d ? (v + MODN - 1) % MODN : (v + 1) % MODN;
  endfunction

  function automatic bit cur_down();
`ifdef CNT_CHK_DIR_EN
    return dir;
`else
    return DOWN != 0;
`endif
  endfunction

  bit m_valid  = 0;
  bit m_locked = 0;
  int m_prev   = 0;
  bit m_prev_en = 0;
  bit m_prev_dn = 0;
  int m_exp = 0, m_cnt = 0, m_cnt2 = 0, m_run = 0;
  bit m_pulse = 0, m_sticky = 0, m_wrap = 0;

  always @(posedge clk) begin
    bit mism;
    if (rst) begin
      m_valid = 1; m_locked = 0; m_exp = 0; m_cnt = 0; m_cnt2 = 0; m_run = 0;
      m_pulse = 0; m_sticky = 0; m_wrap = 0;
    end else begin
      if (!m_locked) begin
        m_locked = 1; m_pulse = 0; m_wrap = 0;
      end else begin
        mism    = (int'(cnt_in) != predict(m_prev, m_prev_en, m_prev_dn));
        m_pulse = mism;
        m_wrap  = !mism && m_prev_en && (m_prev == (m_prev_dn ? 0 : MODN - 1));
        if (mism) begin
          m_sticky = 1;
          m_cnt  = (m_cnt  < (1 << ERR_W) - 1) ? m_cnt  + 1 : m_cnt;
          m_cnt2 = (m_cnt2 < (1 << SAT_W) - 1) ? m_cnt2 + 1 : m_cnt2;
          m_run++;
          if (m_run == LOSS_TH) begin
            m_locked = 0; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      if (clr) begin
        m_cnt = 0; m_cnt2 = 0; m_sticky = 0; m_run = 0;
      end
      m_prev    = int'(cnt_in);
      m_prev_en = en;
      m_prev_dn = cur_down();
      m_exp     = predict(m_prev, en, m_prev_dn);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("a.sync_ok",    32'(a_sync_ok),    32'(m_locked));
      check("a.exp_out",    32'(a_exp_out),    32'(m_exp));
      check("a.err_pulse",  32'(a_err_pulse),  32'(m_pulse));
      check("a.err_sticky", 32'(a_err_sticky), 32'(m_sticky));
      check("a.err_cnt",    32'(a_err_cnt),    32'(m_cnt));
      check("a.wrap_pulse", 32'(a_wrap_pulse), 32'(m_wrap));
      check("b.sync_ok",    32'(b_sync_ok),    32'(m_locked));
      check("b.exp_out",    32'(b_exp_out),    32'(m_exp));
      check("b.err_pulse",  32'(b_err_pulse),  32'(m_pulse));
      check("b.err_sticky", 32'(b_err_sticky), 32'(m_sticky));
      check("b.err_cnt",    32'(b_err_cnt),    32'(m_cnt2));
      check("b.wrap_pulse", 32'(b_wrap_pulse), 32'(m_wrap));
    end
  end

  // ---------------- directed stimulus ----------------
  // Applies one sample and returns just after the edge that consumed it.
  task automatic cyc(input bit e, input int v, input bit c, input bit r);
    en = e; cnt_in = N'(v); clr = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("rst sync_ok", 32'(a_sync_ok), 0);
    check("rst exp_out", 32'(a_exp_out), 0);
    check("rst err_cnt", 32'(a_err_cnt), 0);

    // plain down count 5,4,3,2
    cyc(1, 5, 0, 0);
    check("lock sync_ok", 32'(a_sync_ok), 1);
    check("lock exp_out", 32'(a_exp_out), 4);
    cyc(1, 4, 0, 0);
    cyc(1, 3, 0, 0);
    cyc(1, 2, 0, 0);
    check("count exp_out", 32'(a_exp_out), 1);
    check("count err_cnt", 32'(a_err_cnt), 0);

    // down wrap 1,0,15,14
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check("pre-wrap wrap_pulse", 32'(a_wrap_pulse), 0);
    cyc(1, 15, 0, 0);
    check("wrap wrap_pulse", 32'(a_wrap_pulse), 1);
    cyc(1, 14, 0, 0);
    check("post-wrap wrap_pulse", 32'(a_wrap_pulse), 0);
    check("wrap err_cnt", 32'(a_err_cnt), 0);

    // hold with en=0, then a change while held
    cyc(0, 0, 0, 1);
    cyc(0, 7, 0, 0);
    cyc(0, 7, 0, 0);
    cyc(0, 7, 0, 0);
    check("hold err_pulse", 32'(a_err_pulse), 0);
    cyc(1, 6, 0, 0);
    check("hold-change err_pulse",  32'(a_err_pulse), 1);
    check("hold-change err_sticky", 32'(a_err_sticky), 1);
    check("hold-change err_cnt",    32'(a_err_cnt), 1);
    cyc(1, 5, 0, 0);
    check("after err_pulse", 32'(a_err_pulse), 0);

    // loss of lock after three consecutive mismatches, then relock
    cyc(1, 4, 1, 0);
    check("clr err_cnt", 32'(a_err_cnt), 0);
    cyc(1, 9, 0, 0);
    cyc(1, 2, 0, 0);
    check("2 miss sync_ok", 32'(a_sync_ok), 1);
    cyc(1, 11, 0, 0);
    check("loss sync_ok",   32'(a_sync_ok), 0);
    check("loss err_cnt",   32'(a_err_cnt), 3);
    check("loss err_pulse", 32'(a_err_pulse), 1);
    cyc(1, 4, 0, 0);
    check("relock sync_ok",   32'(a_sync_ok), 1);
    check("relock err_pulse", 32'(a_err_pulse), 0);
    cyc(1, 3, 0, 0);
    cyc(1, 2, 0, 0);
    check("relocked err_cnt", 32'(a_err_cnt), 3);

    // five isolated mismatches: ERR_W=2 saturates at 3
    cyc(1, 1, 1, 0);
    cyc(1, 8, 0, 0);  cyc(1, 7, 0, 0);
    cyc(1, 12, 0, 0); cyc(1, 11, 0, 0);
    cyc(1, 3, 0, 0);  cyc(1, 2, 0, 0);
    cyc(1, 9, 0, 0);  cyc(1, 8, 0, 0);
    cyc(1, 5, 0, 0);  cyc(1, 4, 0, 0);
    check("sat b.err_cnt", 32'(b_err_cnt), 3);
    check("sat a.err_cnt", 32'(a_err_cnt), 5);
    // clr on the same edge as a mismatch
    cyc(1, 10, 1, 0);
    check("clr+miss err_cnt",    32'(b_err_cnt), 0);
    check("clr+miss err_sticky", 32'(b_err_sticky), 0);
    check("clr+miss err_pulse",  32'(b_err_pulse), 1);
    cyc(1, 9, 0, 0);

    // rst mid-TRACK with err_cnt=2
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    cyc(1, 6, 0, 0); cyc(1, 5, 0, 0);
    check("pre-rst err_cnt", 32'(a_err_cnt), 2);
    cyc(1, 4, 1, 1);
    check("mid rst sync_ok",    32'(a_sync_ok), 0);
    check("mid rst err_cnt",    32'(a_err_cnt), 0);
    check("mid rst err_sticky", 32'(a_err_sticky), 0);
    check("mid rst exp_out",    32'(a_exp_out), 0);
    cyc(1, 4, 0, 0);
    check("rst relock sync_ok", 32'(a_sync_ok), 1);
    cyc(1, 3, 0, 0);
    check("rst relock err_pulse", 32'(a_err_pulse), 0);

`ifdef CNT_CHK_DIR_EN
    // up direction wrap 14,15,0
    cyc(0, 0, 0, 1);
    dir = 1'b0;
    cyc(1, 14, 0, 0);
    cyc(1, 15, 0, 0);
    cyc(1, 0, 0, 0);
    check("up wrap_pulse", 32'(a_wrap_pulse), 1);
    cyc(1, 1, 0, 0);
    check("up post wrap_pulse", 32'(a_wrap_pulse), 0);
    check("up err_cnt", 32'(a_err_cnt), 0);
    dir = 1'b1;
`endif

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Passive monitor for the output bus of a parameterised up/down counter. Connects to the same enable as the counter.
- Samples the counter value every clock and predicts the next value from the current sample and enable.
- Reports mismatches, counts errors, and pulses on each correctly observed wrap at the terminal count.
- Used in benches and as an in-design sanity checker alongside counter instances.

Parameters:
- N, 4: width of the checked counter bus.
- DOWN, 1: 1 = checked counter decrements, 0 = increments.
- ERR_W, 8: width of the saturating error counter.
- LOSS_TH, 3: consecutive mismatches that cause loss of lock; must be 1 to 2^ERR_W-1.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: enable of the checked counter, sampled alongside cnt_in.
- cnt_in, input, N: checked counter output.
- clr, input, 1: synchronous clear of error statistics.
- sync_ok, output, 1: checker is locked (TRACK state).
- exp_out, output, N: predicted value for the next sample.
- err_pulse, output, 1: one-cycle pulse per mismatch.
- err_sticky, output, 1: set by any mismatch; cleared by clr or rst.
- err_cnt, output, ERR_W: saturating mismatch count.
- wrap_pulse, output, 1: one-cycle pulse per correctly predicted terminal-count wrap.

Behaviour:
- next(v,e) = e ? (DOWN ? v-1 : v+1) mod 2^N : v.
- Arithmetic is N bits with natural wrap: DOWN 0 -> 2^N-1; up 2^N-1 -> 0.
- Reset (rst=1 at edge):
  - state=SYNC; exp_out=0; consecutive-mismatch count=0.
  - sync_ok, err_pulse, err_sticky, err_cnt, wrap_pulse all 0.
  - rst overrides clr and all other inputs, including mid-TRACK.
- SYNC at edge:
  - exp_out<=next(cnt_in,en); state<=TRACK; sync_ok<=1.
  - No compare is made; err_pulse<=0 and wrap_pulse<=0.
- TRACK at edge:
  - match = (cnt_in==exp_out).
  - exp_out<=next(cnt_in,en). The checker always re-aligns to the observed value, so a single corrupted sample produces two mismatches.
  - err_pulse<=!match.
  - On mismatch: err_sticky<=1; err_cnt<=err_cnt+1, saturating at 2^ERR_W-1.
  - wrap_pulse<=1 when match and the previous sample was the terminal count with enable high (DOWN: previous 0, cnt_in=2^N-1; up: previous 2^N-1, cnt_in=0). Otherwise wrap_pulse<=0.
  - Consecutive mismatch count: cleared on match, incremented on mismatch.
  - When the count reaches LOSS_TH: state<=SYNC, sync_ok<=0, consecutive count<=0. That final mismatch is still counted and pulsed.
- Result latency: one cycle after the sample edge, all outputs registered.
- clr=1 at edge:
  - err_cnt<=0, err_sticky<=0, consecutive count<=0.
  - Takes priority over a same-edge mismatch for those three registers.
  - err_pulse still reflects the mismatch; state and exp_out are unaffected.
- en held low: value must hold. Any change is a mismatch.
- LOSS_TH=1: every mismatch returns the checker to SYNC.

Optional Feature:
- Macro CNT_CHK_DIR_EN.
- Defined: adds an input port dir (1 bit). dir=1 selects decrement, dir=0 increment, sampled each edge with en. DOWN is ignored; wrap detection follows the sampled dir.
- Undefined: no dir port; direction fixed by DOWN.

Test Plan:
- N=4, DOWN=1. rst 2 cycles, then cnt_in 5,4,3,2 with en=1 -> sync_ok=1 one cycle after first sample; err_pulse never 1; err_cnt=0; exp_out=1 after sample 2.
- Down wrap: cnt_in 1,0,15,14 with en=1 -> wrap_pulse high for exactly one cycle, the cycle after the 15 sample; no errors.
- en=0 with cnt_in 7,7,7 -> no error. Then cnt_in 6 while previous en=0 -> err_pulse one cycle, err_sticky=1, err_cnt=1.
- LOSS_TH=3, cnt_in 9,2,11,4 with en=1 -> three mismatches, err_cnt=3, sync_ok=0 after the third. Then 3,2 -> relocks, sync_ok=1, no further errors.
- ERR_W=2: five mismatches -> err_cnt saturates at 3. Then clr on the same edge as a mismatch -> err_cnt=0, err_sticky=0, err_pulse=1.
- rst asserted mid-TRACK with err_cnt=2 -> next cycle all outputs 0, state SYNC. Release -> relocks on first sample. With CNT_CHK_DIR_EN, dir=0 and cnt_in 14,15,0 -> wrap_pulse once, no errors.
